// File: rtl/mem_arbiter.sv
// Two-requester main-memory arbiter for the I-cache and D-cache.
// Define ARB_RR_EN for round-robin on contention; default is fixed D priority.
module mem_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_req,
    input  logic              d_wen,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, MEM_I, MEM_D, RESP} state_t;

    state_t              r_state;
    state_t              w_next;
    logic                w_gnt_i;
    logic                w_gnt_d;
    logic                w_done;
    logic                w_pri_d;
    logic                r_wen;
    logic                r_mem_read;
    logic                r_mem_write;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic [DATA_W-1:0]   r_i_rdata;
    logic [DATA_W-1:0]   r_d_rdata;
    logic                r_i_ready;
    logic                r_d_ready;
    logic                r_busy;

`ifdef ARB_RR_EN
    logic r_pri_d;

    // Flip toward the loser only when both requesters competed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pri_d <= 1'b1;
        end else if (r_state == IDLE && i_req && d_req) begin
            r_pri_d <= ~r_pri_d;
        end
    end

    assign w_pri_d = r_pri_d;
`else
    assign w_pri_d = 1'b1;
`endif

    always_comb begin
        w_next  = r_state;
        w_gnt_i = 1'b0;
        w_gnt_d = 1'b0;
        w_done  = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_gnt_d = d_req & (~i_req | w_pri_d);
                w_gnt_i = i_req & ~w_gnt_d;
                if (w_gnt_d) begin
                    w_next = MEM_D;
                end else if (w_gnt_i) begin
                    w_next = MEM_I;
                end
            end
            MEM_I, MEM_D: begin
                if (mem_ready) begin
                    w_done = 1'b1;
                    w_next = RESP;
                end
            end
            RESP: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_wen       <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_i_rdata   <= '0;
            r_d_rdata   <= '0;
            r_i_ready   <= 1'b0;
            r_d_ready   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_busy    <= (w_next != IDLE);
            r_i_ready <= 1'b0;
            r_d_ready <= 1'b0;
            if (w_gnt_i) begin
                r_mem_addr  <= i_addr;
                r_mem_read  <= 1'b1;
                r_mem_write <= 1'b0;
            end
            if (w_gnt_d) begin
                r_mem_addr  <= d_addr;
                r_mem_wdata <= d_wdata;
                r_wen       <= d_wen;
                r_mem_read  <= ~d_wen;
                r_mem_write <= d_wen;
            end
            if (w_done) begin
                r_mem_read  <= 1'b0;
                r_mem_write <= 1'b0;
                if (r_state == MEM_I) begin
                    r_i_rdata <= mem_rdata;
                    r_i_ready <= 1'b1;
                end else begin
                    // Write-backs leave the last fill line visible.
                    if (!r_wen) begin
                        r_d_rdata <= mem_rdata;
                    end
                    r_d_ready <= 1'b1;
                end
            end
        end
    end

    assign mem_read  = r_mem_read;
    assign mem_write = r_mem_write;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign i_rdata   = r_i_rdata;
    assign d_rdata   = r_d_rdata;
    assign i_ready   = r_i_ready;
    assign d_ready   = r_d_ready;
    assign busy      = r_busy;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter.
// Contention expectations follow ARB_RR_EN when it is defined.
module tb_mem_arbiter;

    localparam int AW = 28;
    localparam int DW = 128;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          i_ready;
    logic          d_req;
    logic          d_wen;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_ready;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;
    logic          busy;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [DW-1:0] LINE_I = 128'hDEADBEEF_01234567_89ABCDEF_00112233;
    localparam logic [DW-1:0] LINE_W = 128'h12345678_9ABCDEF0_0F1E2D3C_4B5A6978;
    localparam logic [DW-1:0] LINE_D = 128'hCAFEF00D_55AA55AA_13579BDF_2468ACE0;
    localparam logic [DW-1:0] JUNK   = 128'hFFFF0000_FFFF0000_FFFF0000_FFFF0000;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
        .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .busy(busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called in the first strobe cycle; zero-wait memory; returns in IDLE.
    task automatic txn(input string tag, input logic [AW-1:0] exp_addr,
                       input bit is_i, input logic [DW-1:0] line);
        chk({tag, ".addr"}, DW'(mem_addr), DW'(exp_addr));
        chk({tag, ".rd"}, DW'(mem_read), 128'd1);
        chk({tag, ".wr"}, DW'(mem_write), 128'd0);
        mem_ready = 1'b1;
        mem_rdata = line;
        tick();
        mem_ready = 1'b0;
        chk({tag, ".iready"}, DW'(i_ready), DW'(is_i));
        chk({tag, ".dready"}, DW'(d_ready), DW'(!is_i));
        chk({tag, ".data"}, is_i ? i_rdata : d_rdata, line);
        tick();
        chk({tag, ".idle"}, DW'(busy), 128'd0);
    endtask

    initial begin
        rst = 1'b1;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_wen = 1'b0; d_addr = '0; d_wdata = '0;
        mem_rdata = '0; mem_ready = 1'b0;
        tick();
        tick();
        chk("rst.busy", DW'(busy), 128'd0);
        chk("rst.rd", DW'(mem_read), 128'd0);
        chk("rst.addr", DW'(mem_addr), 128'd0);
        rst = 1'b0;
        tick();

        // Lone I fill, 4-cycle memory, address changed mid-flight.
        i_req = 1'b1;
        i_addr = 28'h0000010;
        tick();
        chk("i.rd", DW'(mem_read), 128'd1);
        chk("i.wr", DW'(mem_write), 128'd0);
        chk("i.addr", DW'(mem_addr), 128'h10);
        chk("i.busy", DW'(busy), 128'd1);
        i_addr = 28'h0000ABC;
        tick();
        tick();
        tick();
        chk("i.hold_addr", DW'(mem_addr), 128'h10);
        chk("i.noready", DW'(i_ready), 128'd0);
        mem_ready = 1'b1;
        mem_rdata = LINE_I;
        tick();
        mem_ready = 1'b0;
        i_req = 1'b0;
        chk("i.ready", DW'(i_ready), 128'd1);
        chk("i.data", i_rdata, LINE_I);
        chk("i.rd_drop", DW'(mem_read), 128'd0);
        tick();
        chk("i.pulse1", DW'(i_ready), 128'd0);
        chk("i.idle", DW'(busy), 128'd0);
        chk("i.hold_data", i_rdata, LINE_I);

        // Stray mem_ready in IDLE.
        mem_ready = 1'b1;
        mem_rdata = JUNK;
        tick();
        mem_ready = 1'b0;
        tick();
        chk("stray.iready", DW'(i_ready), 128'd0);
        chk("stray.dready", DW'(d_ready), 128'd0);
        chk("stray.busy", DW'(busy), 128'd0);

        // D write-back, then fill presented during RESP.
        d_req = 1'b1;
        d_wen = 1'b1;
        d_addr = 28'h0000020;
        d_wdata = LINE_W;
        tick();
        chk("wb.wr", DW'(mem_write), 128'd1);
        chk("wb.rd", DW'(mem_read), 128'd0);
        chk("wb.wdata", mem_wdata, LINE_W);
        chk("wb.addr", DW'(mem_addr), 128'h20);
        mem_ready = 1'b1;
        mem_rdata = JUNK;
        tick();
        mem_ready = 1'b0;
        d_wen = 1'b0;
        d_addr = 28'h0000030;
        chk("wb.ready", DW'(d_ready), 128'd1);
        chk("wb.rdata_kept", d_rdata, 128'd0);
        chk("wb.wr_drop", DW'(mem_write), 128'd0);
        tick();
        chk("wb.idle", DW'(busy), 128'd0);
        chk("wb.pulse1", DW'(d_ready), 128'd0);
        tick();
        txn("fill", 28'h0000030, 1'b0, LINE_D);
        d_req = 1'b0;
        tick();

        // Contention: both request together.
        i_req = 1'b1;
        i_addr = 28'h0000040;
        d_req = 1'b1;
        d_addr = 28'h0000050;
        tick();
        for (int g = 0; g < 4; g++) begin
            bit is_i;
`ifdef ARB_RR_EN
            is_i = (g % 2) == 1;
`else
            is_i = (g == 3);
`endif
            txn($sformatf("arb%0d", g), is_i ? 28'h40 : 28'h50, is_i,
                LINE_I ^ DW'(g + 1));
            if (g == 2) d_req = 1'b0;
            if (g == 3) i_req = 1'b0;
            tick();
        end
        chk("arb.idle", DW'(busy), 128'd0);

        // Reset during a write-back; late mem_ready is ignored.
        d_req = 1'b1;
        d_wen = 1'b1;
        d_addr = 28'h0000060;
        d_wdata = LINE_W;
        tick();
        chk("rr.wr", DW'(mem_write), 128'd1);
        rst = 1'b1;
        d_req = 1'b0;
        tick();
        rst = 1'b0;
        chk("rr.wr0", DW'(mem_write), 128'd0);
        chk("rr.rd0", DW'(mem_read), 128'd0);
        chk("rr.addr0", DW'(mem_addr), 128'd0);
        chk("rr.wdata0", mem_wdata, 128'd0);
        chk("rr.irdata0", i_rdata, 128'd0);
        chk("rr.drdata0", d_rdata, 128'd0);
        chk("rr.busy0", DW'(busy), 128'd0);
        tick();
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        chk("rr.late_dready", DW'(d_ready), 128'd0);
        chk("rr.late_busy", DW'(busy), 128'd0);
        tick();
        chk("rr.late_dready2", DW'(d_ready), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
